arc4_key_search_ctrl: RTL and testbench

Controller that sequences the arc4 decryption core through a range of candidate keys until a plausible plaintext is produced. For each key it starts arc4 with the en/rdy handshake and waits for completion. It then takes over the plaintext memory port and scans the length-prefixed plaintext for printable characters. It reports the first key that passes, or reports that no key in the range passes.

---
 rtl/arc4_key_search_ctrl.sv | 164 ++++++++++++++++
 tb/tb_arc4_key_search_ctrl.sv | 233 +++++++++++++++++++++++
 2 files changed

// File: rtl/arc4_key_search_ctrl.sv
// Key-search sequencer: runs the arc4 core for each candidate key, then scans the
// length-prefixed plaintext for printable bytes. Optional KEY_SEARCH_COUNT_EN adds keys_tried_o.
module arc4_key_search_ctrl #(
    parameter logic [23:0] KEY_FIRST = 24'h000000,
    parameter logic [23:0] KEY_LAST  = 24'hFFFFFF,
    parameter logic [7:0]  CHAR_LO   = 8'h20,
    parameter logic [7:0]  CHAR_HI   = 8'h7E
) (
    input  logic        clk_i,
    input  logic        rst_n_i,
    input  logic        en_i,
    output logic        rdy_o,
    output logic        key_valid_o,
    output logic [23:0] key_o,
    output logic        a4_en_o,
    input  logic        a4_rdy_i,
    output logic [23:0] a4_key_o,
    output logic        pt_sel_o,
    output logic [7:0]  pt_addr_o,
    input  logic [7:0]  pt_rddata_i
`ifdef KEY_SEARCH_COUNT_EN
    ,
    output logic [23:0] keys_tried_o
`endif
);

    typedef enum logic [2:0] {
        S_IDLE, S_START, S_WAIT_BUSY, S_WAIT_DONE, S_LEN, S_SCAN, S_PASS, S_FAIL
    } state_t;

    state_t      state_q, state_d;
    logic [23:0] a4_key_q, a4_key_d;
    logic [23:0] key_q, key_d;
    logic        key_valid_q, key_valid_d;
    logic [7:0]  len_q, len_d;
    logic [7:0]  idx_q, idx_d;
    logic        byte_ok;
`ifdef KEY_SEARCH_COUNT_EN
    logic [23:0] cnt_q, cnt_d;
`endif

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_q     <= S_IDLE;
            a4_key_q    <= KEY_FIRST;
            key_q       <= '0;
            key_valid_q <= 1'b0;
            len_q       <= '0;
            idx_q       <= '0;
`ifdef KEY_SEARCH_COUNT_EN
            cnt_q       <= '0;
`endif
        end else begin
            state_q     <= state_d;
            a4_key_q    <= a4_key_d;
            key_q       <= key_d;
            key_valid_q <= key_valid_d;
            len_q       <= len_d;
            idx_q       <= idx_d;
`ifdef KEY_SEARCH_COUNT_EN
            cnt_q       <= cnt_d;
`endif
        end
    end

    assign byte_ok = (pt_rddata_i >= CHAR_LO) && (pt_rddata_i <= CHAR_HI);

    // Read addresses are issued combinationally so each byte returns the very next cycle.
    always_comb begin
        state_d     = state_q;
        a4_key_d    = a4_key_q;
        key_d       = key_q;
        key_valid_d = key_valid_q;
        len_d       = len_q;
        idx_d       = idx_q;
        a4_en_o     = 1'b0;
        pt_sel_o    = 1'b0;
        pt_addr_o   = 8'h00;
`ifdef KEY_SEARCH_COUNT_EN
        cnt_d       = cnt_q;
`endif
        case (state_q)
            S_IDLE: begin
                if (en_i) begin
                    state_d     = S_START;
                    key_valid_d = 1'b0;
                    a4_key_d    = KEY_FIRST;
`ifdef KEY_SEARCH_COUNT_EN
                    cnt_d       = '0;
`endif
                end
            end
            S_START: begin
                if (a4_rdy_i) begin
                    a4_en_o = 1'b1;
                    state_d = S_WAIT_BUSY;
                end
            end
            S_WAIT_BUSY: begin
                if (!a4_rdy_i) state_d = S_WAIT_DONE;
            end
            S_WAIT_DONE: begin
                if (a4_rdy_i) begin
                    pt_sel_o = 1'b1;
                    state_d  = S_LEN;
                end
            end
            S_LEN: begin
                pt_sel_o = 1'b1;
                len_d    = pt_rddata_i;
                if (pt_rddata_i == 8'h00) begin
                    state_d = S_PASS;
                end else begin
                    pt_addr_o = 8'h01;
                    idx_d     = 8'h01;
                    state_d   = S_SCAN;
                end
            end
            S_SCAN: begin
                // pt_rddata_i holds the byte at idx_q; stop issuing on the first bad byte.
                pt_sel_o  = 1'b1;
                pt_addr_o = idx_q;
                if (!byte_ok) begin
                    state_d = S_FAIL;
                end else if (idx_q == len_q) begin
                    state_d = S_PASS;
                end else begin
                    pt_addr_o = idx_q + 8'd1;
                    idx_d     = idx_q + 8'd1;
                end
            end
            S_PASS: begin
                key_d       = a4_key_q;
                key_valid_d = 1'b1;
                state_d     = S_IDLE;
`ifdef KEY_SEARCH_COUNT_EN
                if (cnt_q != 24'hFFFFFF) cnt_d = cnt_q + 24'd1;
`endif
            end
            S_FAIL: begin
`ifdef KEY_SEARCH_COUNT_EN
                if (cnt_q != 24'hFFFFFF) cnt_d = cnt_q + 24'd1;
`endif
                if (a4_key_q == KEY_LAST) begin
                    key_valid_d = 1'b0;
                    state_d     = S_IDLE;
                end else begin
                    a4_key_d = a4_key_q + 24'd1;
                    state_d  = S_START;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    assign rdy_o       = (state_q == S_IDLE);
    assign key_valid_o = key_valid_q;
    assign key_o       = key_q;
    assign a4_key_o    = a4_key_q;
`ifdef KEY_SEARCH_COUNT_EN
    assign keys_tried_o = cnt_q;
`endif

endmodule

// File: tb/tb_arc4_key_search_ctrl.sv
// Scoreboard bench: three controllers with different key ranges, each driving a
// behavioural arc4 core and plaintext memory whose contents depend on the test mode.
module tb_arc4_key_search_ctrl;

    localparam int N = 3;
    localparam logic [23:0] KF [N] = '{24'h000000, 24'h000000, 24'h00ABCD};
    localparam logic [23:0] KL [N] = '{24'h00001F, 24'h000005, 24'h00ABCF};

    localparam int M_ABC = 0, M_7F = 1, M_BIN = 2, M_B1F = 3, M_B7F = 4, M_L0 = 5, M_LONG = 6;

    typedef struct {
        int          inst;
        logic        kv;
        logic [23:0] key;
        int          pulses;
        int          maxa;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        clr;
    int          mode;
    logic        en      [N];
    logic        rdy     [N];
    logic        kv      [N];
    logic [23:0] key     [N];
    logic        a4_en   [N];
    logic        a4_rdy  [N];
    logic [23:0] a4_key  [N];
    logic        pt_sel  [N];
    logic [7:0]  pt_addr [N];
    logic [7:0]  rdd     [N];
    int          pulses  [N];
    int          maxa    [N];
`ifdef KEY_SEARCH_COUNT_EN
    logic [23:0] kt      [N];
`endif

    exp_t q[$];
    int   nt = 0, nf = 0, ndone = 0, ovl = 0;

    always #5 clk = ~clk;

    function automatic logic [7:0] pt_byte(input int m, input logic [23:0] k, input logic [7:0] a);
        case (m)
            M_ABC:  if (a == 8'd0) return 8'd3;
                    else if (k != 24'h000018) return 8'h01;
                    else return (a == 8'd1) ? 8'h41 : (a == 8'd2) ? 8'h42 : 8'h43;
            M_7F:   return (a == 8'd0) ? 8'd3 : (a == 8'd2) ? 8'h7F : 8'h41;
            M_BIN:  return (a == 8'd0) ? 8'd2 : (a == 8'd1) ? 8'h20 : 8'h7E;
            M_B1F:  return (a == 8'd0) ? 8'd1 : 8'h1F;
            M_B7F:  return (a == 8'd0) ? 8'd1 : 8'h7F;
            M_LONG: return (a == 8'd0) ? 8'd200 : (a == 8'd200) ? 8'h00 : 8'h41;
            default: return 8'h00;
        endcase
    endfunction

    for (genvar g = 0; g < N; g++) begin : g_dut
        int bcnt;
        arc4_key_search_ctrl #(
            .KEY_FIRST(KF[g]), .KEY_LAST(KL[g]), .CHAR_LO(8'h20), .CHAR_HI(8'h7E)
        ) u_dut (
            .clk_i(clk), .rst_n_i(rst_n), .en_i(en[g]), .rdy_o(rdy[g]),
            .key_valid_o(kv[g]), .key_o(key[g]), .a4_en_o(a4_en[g]), .a4_rdy_i(a4_rdy[g]),
            .a4_key_o(a4_key[g]), .pt_sel_o(pt_sel[g]), .pt_addr_o(pt_addr[g]),
            .pt_rddata_i(rdd[g])
`ifdef KEY_SEARCH_COUNT_EN
            , .keys_tried_o(kt[g])
`endif
        );

        // arc4 stand-in: busy for three cycles after each start pulse.
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                a4_rdy[g] <= 1'b1;
                bcnt      <= 0;
                rdd[g]    <= 8'h00;
            end else begin
                if (a4_en[g]) begin
                    a4_rdy[g] <= 1'b0;
                    bcnt      <= 3;
                end else if (!a4_rdy[g]) begin
                    bcnt <= bcnt - 1;
                    if (bcnt == 1) a4_rdy[g] <= 1'b1;
                end
                rdd[g] <= pt_sel[g] ? pt_byte(mode, a4_key[g], pt_addr[g]) : 8'h00;
            end
        end

        always_ff @(posedge clk) begin
            if (clr) begin
                pulses[g] <= 0;
                maxa[g]   <= 0;
            end else begin
                if (a4_en[g]) pulses[g] <= pulses[g] + 1;
                if (pt_sel[g] && int'(pt_addr[g]) > maxa[g]) maxa[g] <= int'(pt_addr[g]);
            end
        end
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        nt++;
        if (act !== exp) begin
            nf++;
            $display("FAIL %s: got %0h, want %0h", nm, act, exp);
        end
    endtask

    // Monitor: pops an expectation whenever a controller returns to rdy.
    initial begin
        logic prev [N];
        exp_t e;
        for (int i = 0; i < N; i++) prev[i] = 1'b1;
        forever begin
            @(negedge clk);
            for (int i = 0; i < N; i++) begin
                if (!rst_n) begin
                    prev[i] = 1'b1;
                end else begin
                    if (pt_sel[i] && (a4_en[i] || !a4_rdy[i])) ovl++;
                    if (rdy[i] && !prev[i]) begin
                        if (q.size() == 0) begin
                            chk("unexpected_done", 32'(i), 32'hFFFF_FFFF);
                        end else begin
                            e = q.pop_front();
                            chk("done_inst", 32'(i), 32'(e.inst));
                            chk("key_valid", 32'(kv[i]), 32'(e.kv));
                            if (e.kv) chk("key", 32'(key[i]), 32'(e.key));
                            chk("a4_en_pulses", 32'(pulses[i]), 32'(e.pulses));
                            chk("max_pt_addr", 32'(maxa[i]), 32'(e.maxa));
`ifdef KEY_SEARCH_COUNT_EN
                            chk("keys_tried", 32'(kt[i]), 32'(e.pulses));
`endif
                        end
                        ndone++;
                    end
                    prev[i] = rdy[i];
                end
            end
        end
    end

    task automatic launch(input int i, input int m);
        mode = m;
        @(negedge clk); clr = 1'b1;
        @(negedge clk); clr = 1'b0; en[i] = 1'b1;
        @(negedge clk); en[i] = 1'b0;
    endtask

    task automatic wait_done(input int d0);
        for (int c = 0; c < 3000; c++) begin
            if (ndone != d0) return;
            @(negedge clk);
        end
        chk("done_timeout", 32'(ndone), 32'(d0 + 1));
        q.delete();
    endtask

    task automatic expect_res(input int i, input logic k_v, input logic [23:0] k, input int p, input int ma);
        exp_t e;
        e.inst = i; e.kv = k_v; e.key = k; e.pulses = p; e.maxa = ma;
        q.push_back(e);
    endtask

    task automatic run(input int i, input int m, input logic k_v, input logic [23:0] k, input int p, input int ma);
        int d0;
        expect_res(i, k_v, k, p, ma);
        d0 = ndone;
        launch(i, m);
        wait_done(d0);
    endtask

    task automatic wait_cond_key(input int i, input logic [23:0] k, input logic [7:0] a, input string nm);
        int c;
        c = 0;
        while (!(pt_sel[i] && a4_key[i] == k && pt_addr[i] == a) && c < 5000) begin
            @(negedge clk);
            c++;
        end
        if (c >= 5000) chk(nm, 32'(c), 32'd0);
    endtask

    initial begin
        int d0;
        rst_n = 1'b0; clr = 1'b1; mode = M_ABC;
        for (int i = 0; i < N; i++) en[i] = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_rdy", 32'(rdy[0]), 32'd1);
        chk("rst_key_valid", 32'(kv[0]), 32'd0);
        chk("rst_key", 32'(key[0]), 32'd0);
        chk("rst_a4_en", 32'(a4_en[0]), 32'd0);
        chk("rst_a4_key_first", 32'(a4_key[2]), 32'h00ABCD);
        chk("rst_pt_sel", 32'(pt_sel[0]), 32'd0);
        chk("rst_pt_addr", 32'(pt_addr[0]), 32'd0);
        rst_n = 1'b1; clr = 1'b0;
        repeat (2) @(negedge clk);

        // "ABC" readable only under key 0x18, with an ignored en during a SCAN.
        expect_res(0, 1'b1, 24'h000018, 25, 3);
        d0 = ndone;
        launch(0, M_ABC);
        wait_cond_key(0, 24'h000002, 8'h01, "scan_wait_timeout");
        @(negedge clk); en[0] = 1'b1;
        @(negedge clk); en[0] = 1'b0;
        wait_done(d0);

        run(1, M_7F,  1'b0, 24'h0, 6, 2);
        run(0, M_BIN, 1'b1, 24'h000000, 1, 2);
        run(1, M_B1F, 1'b0, 24'h0, 6, 1);
        run(1, M_B7F, 1'b0, 24'h0, 6, 1);
        run(2, M_L0,  1'b1, 24'h00ABCD, 1, 0);

        // Async reset in the middle of key 3's scan.
        launch(0, M_LONG);
        wait_cond_key(0, 24'h000003, 8'h0A, "long_wait_timeout");
        #1 rst_n = 1'b0;
        #1;
        chk("async_rdy", 32'(rdy[0]), 32'd1);
        chk("async_key_valid", 32'(kv[0]), 32'd0);
        chk("async_pt_sel", 32'(pt_sel[0]), 32'd0);
        chk("async_a4_key", 32'(a4_key[0]), 32'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        run(0, M_ABC, 1'b1, 24'h000018, 25, 3);

        chk("sel_overlap", 32'(ovl), 32'd0);
        chk("queue_empty", 32'(q.size()), 32'd0);
        $display("[TB] %0d tests run, %0d failed", nt, nf);
        $finish;
    end

endmodule
